// File: rtl/nn_stream_loader.sv
// Stream loader: decodes command headers from a 32-bit valid/ready word stream
// and turns each command's data words into registered memory write strobes.
module nn_stream_loader #(
  parameter int NU_COUNT       = 4,
  parameter int Q_SIZE         = 16,
  parameter int XY_MEM_DEPTH   = 8,
  parameter int W_MEM_DEPTH    = 8,
  parameter int INST_MEM_DEPTH = 8,
  parameter int INST_MEM_SIZE  = 32,
  parameter int ACT_LUT_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [31:0]               s_data,
  output logic                      xy_write_enable,
  output logic [XY_MEM_DEPTH-1:0]   xy_write_addr,
  output logic [Q_SIZE-1:0]         xy_write_data,
  output logic [NU_COUNT-1:0]       w_write_enable,
  output logic [W_MEM_DEPTH-1:0]    w_write_addr,
  output logic [Q_SIZE-1:0]         w_write_data,
  output logic                      inst_write_enable,
  output logic [INST_MEM_DEPTH-1:0] inst_write_addr,
  output logic [INST_MEM_SIZE-1:0]  inst_write_data,
  output logic                      act_write_enable,
  output logic [ACT_LUT_DEPTH-1:0]  act_write_addr,
  output logic [Q_SIZE-1:0]         act_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  localparam logic [1:0] TGT_XY   = 2'b00;
  localparam logic [1:0] TGT_W    = 2'b01;
  localparam logic [1:0] TGT_INST = 2'b10;
  localparam logic [1:0] TGT_ACT  = 2'b11;

  state_e state_q, state_d;

  logic [1:0]  target_q;
  logic [5:0]  lane_q;
  logic [11:0] base_q;
  logic [11:0] count_q;
  logic [11:0] idx_q;

  logic                      xyWe_q;
  logic [XY_MEM_DEPTH-1:0]   xyAddr_q;
  logic [Q_SIZE-1:0]         xyData_q;
  logic [NU_COUNT-1:0]       wWe_q;
  logic [W_MEM_DEPTH-1:0]    wAddr_q;
  logic [Q_SIZE-1:0]         wData_q;
  logic                      instWe_q;
  logic [INST_MEM_DEPTH-1:0] instAddr_q;
  logic [INST_MEM_SIZE-1:0]  instData_q;
  logic                      actWe_q;
  logic [ACT_LUT_DEPTH-1:0]  actAddr_q;
  logic [Q_SIZE-1:0]         actData_q;
  logic                      done_q;
  logic                      error_q;

  logic        accept;
  logic [1:0]  hdrTarget;
  logic [5:0]  hdrLane;
  logic [11:0] hdrCount;
  logic        laneBad;
  logic        lastWord;
  logic [11:0] addrSum;
  logic [NU_COUNT-1:0] wLaneMask;

  assign accept    = s_valid && s_ready;
  assign hdrTarget = s_data[31:30];
  assign hdrLane   = s_data[29:24];
  assign hdrCount  = s_data[11:0];
  assign laneBad   = (hdrTarget == TGT_W) && (32'(hdrLane) >= 32'(NU_COUNT));
  assign lastWord  = (idx_q == count_q - 12'd1);
  // 12-bit sum, truncated per target below so writes wrap within each memory
  assign addrSum   = base_q + idx_q;

  always_comb begin
    wLaneMask = '0;
    for (int n = 0; n < NU_COUNT; n++) begin
      wLaneMask[n] = (32'(lane_q) == 32'(n));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && hdrCount != 12'd0) state_d = laneBad ? DRAIN : LOAD;
      end
      LOAD, DRAIN: begin
        if (accept && lastWord) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready never depends on s_valid; every state can take a word
  always_comb begin
    s_ready = 1'b1;
    busy    = 1'b0;
    case (state_q)
      LOAD, DRAIN: busy = 1'b1;
      default:     busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q   <= '0;
      lane_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      xyWe_q     <= 1'b0;
      xyAddr_q   <= '0;
      xyData_q   <= '0;
      wWe_q      <= '0;
      wAddr_q    <= '0;
      wData_q    <= '0;
      instWe_q   <= 1'b0;
      instAddr_q <= '0;
      instData_q <= '0;
      actWe_q    <= 1'b0;
      actAddr_q  <= '0;
      actData_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      xyWe_q   <= 1'b0;
      wWe_q    <= '0;
      instWe_q <= 1'b0;
      actWe_q  <= 1'b0;
      done_q   <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            target_q <= hdrTarget;
            lane_q   <= hdrLane;
            base_q   <= s_data[23:12];
            count_q  <= hdrCount;
            idx_q    <= '0;
            if (hdrCount == 12'd0) done_q <= 1'b1;
            else if (laneBad)      error_q <= 1'b1;
          end
          LOAD: begin
            idx_q <= idx_q + 12'd1;
            if (lastWord) done_q <= 1'b1;
            case (target_q)
              TGT_XY: begin
                xyWe_q   <= 1'b1;
                xyAddr_q <= addrSum[XY_MEM_DEPTH-1:0];
                xyData_q <= s_data[Q_SIZE-1:0];
              end
              TGT_W: begin
                wWe_q   <= wLaneMask;
                wAddr_q <= addrSum[W_MEM_DEPTH-1:0];
                wData_q <= s_data[Q_SIZE-1:0];
              end
              TGT_INST: begin
                instWe_q   <= 1'b1;
                instAddr_q <= addrSum[INST_MEM_DEPTH-1:0];
                instData_q <= s_data[INST_MEM_SIZE-1:0];
              end
              default: begin
                actWe_q   <= 1'b1;
                actAddr_q <= addrSum[ACT_LUT_DEPTH-1:0];
                actData_q <= s_data[Q_SIZE-1:0];
              end
            endcase
          end
          DRAIN: begin
            idx_q <= idx_q + 12'd1;
            if (lastWord) done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign xy_write_enable   = xyWe_q;
  assign xy_write_addr     = xyAddr_q;
  assign xy_write_data     = xyData_q;
  assign w_write_enable    = wWe_q;
  assign w_write_addr      = wAddr_q;
  assign w_write_data      = wData_q;
  assign inst_write_enable = instWe_q;
  assign inst_write_addr   = instAddr_q;
  assign inst_write_data   = instData_q;
  assign act_write_enable  = actWe_q;
  assign act_write_addr    = actAddr_q;
  assign act_write_data    = actData_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule
